// File: rtl/ws28xx_pkg.sv
// Shared types and RAM word layout for the WS28xx frame scheduler.
package ws28xx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PEND = 2'd2
    } sched_state_t;

    localparam logic [7:0] LINK_END  = 8'h00;
    localparam int         PIXEL_MAX = 256;

    localparam int LINK_MSB  = 31;
    localparam int LINK_LSB  = 24;
    localparam int COLOR_MSB = 23;

    function automatic logic [LINK_MSB:0] pack_word(input logic [LINK_MSB-LINK_LSB:0] link,
                                                    input logic [COLOR_MSB:0]         color);
        pack_word = {link, color};
    endfunction

endpackage

// File: rtl/ws28xx_refresh_timer.sv
// Free-running refresh counter; tick is high for the last cycle of each period.
module ws28xx_refresh_timer #(
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0] count_q;

    assign tick_o = (count_q == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (tick_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/ws28xx_frame_sched.sv
// Double-buffered frame scheduler feeding the WS28xx bit controller.
// Optional WS28XX_SCHED_REPEAT_EN re-sends the front frame on idle refresh ticks.
module ws28xx_frame_sched
    import ws28xx_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [23:0] wr_data_i,
    input  logic        wr_last_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    output logic        ram_wr_en_o,
    output logic [8:0]  ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o,
    output logic        ram_rd_bank_o,
    output logic        out_sync_o,
    output logic        frame_pend_o
);

    localparam logic [7:0] ADDR_MAX = 8'(PIXEL_MAX - 1);

    sched_state_t state_q, state_d;
    logic [7:0]   addr_q;
    logic         ready_q;
    logic         front_bank_q;
    logic         sync_q;
    logic         tick;
    logic         hs;
    logic         last_eff;
    logic         swap;
    logic         resend;

    logic         wr_en_p1;
    logic [8:0]   wr_addr_p1;
    logic [31:0]  wr_data_p1;

    function automatic logic [7:0] next_link(input logic [7:0] addr, input logic last);
        next_link = last ? LINK_END : addr + 8'd1;
    endfunction

    ws28xx_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .tick_o (tick)
    );

    // A full bank (address 255) closes the frame even without wr_last_i.
    assign hs       = wr_valid_i & ready_q;
    assign last_eff = wr_last_i | (addr_q == ADDR_MAX);

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            IDLE: if (hs) state_d = last_eff ? PEND : FILL;
            FILL: if (hs && last_eff) state_d = PEND;
            PEND: begin
                if (tick) begin
                    state_d = IDLE;
                    swap    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef WS28XX_SCHED_REPEAT_EN
    // Only a frame committed since the last reset may be repeated.
    logic front_vld_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            front_vld_q <= 1'b0;
        end else if (swap) begin
            front_vld_q <= 1'b1;
        end
    end

    assign resend = tick & (state_q != PEND) & front_vld_q;
`else
    assign resend = 1'b0;
`endif

    // Stage p1: registered RAM write, bank swap and start strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q       <= '0;
            ready_q      <= 1'b0;
            front_bank_q <= 1'b0;
            sync_q       <= 1'b0;
            wr_en_p1     <= 1'b0;
            wr_addr_p1   <= '0;
            wr_data_p1   <= '0;
        end else begin
            ready_q  <= (state_d != PEND);
            sync_q   <= swap | resend;
            wr_en_p1 <= hs;
            if (swap) begin
                front_bank_q <= ~front_bank_q;
            end
            if (hs) begin
                wr_addr_p1 <= {~front_bank_q, addr_q};
                wr_data_p1 <= pack_word(next_link(addr_q, last_eff), wr_data_i);
                addr_q     <= last_eff ? 8'd0 : addr_q + 8'd1;
            end
        end
    end

    assign wr_ready_o    = ready_q;
    assign frame_pend_o  = (state_q == PEND);
    assign ram_rd_bank_o = front_bank_q;
    assign out_sync_o    = sync_q;
    assign ram_wr_en_o   = wr_en_p1;
    assign ram_wr_addr_o = wr_addr_p1;
    assign ram_wr_data_o = wr_data_p1;

endmodule
